regfile_mp: RTL and testbench

//   Parametrised multi-port register file for the CPU datapath; successor to the 2R/1W regfile.
//   - NREAD combinational read ports, each with same-cycle write-to-read bypass.
//   - Two write ports (A = ALU writeback, B = load writeback).
//   - Optional hardwired-zero register 0.
//   - Per-register busy scoreboard; decode uses it to detect RAW hazards.
//

---
 rtl/regfile_mp.sv | 103 ++++++++++
 tb/tb_regfile_mp.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD bypassed combinational read ports and two write ports (B wins over A).
// Per-register busy scoreboard for RAW hazard detection; optional hardwired-zero register 0.
module regfile_mp #(
   parameter int WORD    = 32,
   parameter int DEPTH   = 32,
   parameter int NREAD   = 2,
   parameter bit ZERO_R0 = 1'b1,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_a,
   input  logic [AW-1:0]         waddr_a,
   input  logic [WORD-1:0]       wdata_a,
   input  logic                  we_b,
   input  logic [AW-1:0]         waddr_b,
   input  logic [WORD-1:0]       wdata_b,
   input  logic                  set_busy,
   input  logic [AW-1:0]         busy_addr,
   input  logic [NREAD*AW-1:0]   raddr,
   output logic [NREAD*WORD-1:0] rdata,
   output logic [NREAD-1:0]      rbusy
);

   logic [WORD-1:0] mem_r [DEPTH];
   logic [DEPTH-1:0] busy_r;
   logic [DEPTH-1:0] busy_nxt_s;
   logic wa_ok_s;
   logic wb_ok_s;
   logic sb_ok_s;

   // An address names real storage when it is in range and is not the hardwired zero register.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (int'(a) < DEPTH) && !((ZERO_R0 == 1'b1) && (a == {AW{1'b0}}));
   endfunction

   assign wa_ok_s = we_a & addr_ok(waddr_a);
   assign wb_ok_s = we_b & addr_ok(waddr_b);
   assign sb_ok_s = set_busy & addr_ok(busy_addr);

   // Next busy vector: writes retire the producer, a same-cycle set_busy re-arms it.
   always_comb begin
      busy_nxt_s = busy_r;
      for (int i = 0; i < DEPTH; i++) begin
         busy_nxt_s[i] = (busy_r[i] & ~((wa_ok_s && (int'(waddr_a) == i)) ||
                                        (wb_ok_s && (int'(waddr_b) == i))))
                         | (sb_ok_s && (int'(busy_addr) == i));
      end
   end

   // Register storage and scoreboard; port B is written last so it wins a collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WORD{1'b0}};
         end
         busy_r <= {DEPTH{1'b0}};
      end else begin
         if (wa_ok_s) begin
            mem_r[waddr_a] <= wdata_a;
         end
         if (wb_ok_s) begin
            mem_r[waddr_b] <= wdata_b;
         end
         busy_r <= busy_nxt_s;
      end
   end

   for (genvar p = 0; p < NREAD; p++) begin : g_rd
      logic [AW-1:0]   ra_s;
      logic            ok_s;
      logic            hit_a_s;
      logic            hit_b_s;
      logic [WORD-1:0] rd_s;
      logic            bz_s;

      assign ra_s    = raddr[p*AW +: AW];
      assign ok_s    = addr_ok(ra_s);
      assign hit_a_s = wa_ok_s && (waddr_a == ra_s);
      assign hit_b_s = wb_ok_s && (waddr_b == ra_s);

      // Read mux: a register being written this cycle returns the new data and is not busy.
      always_comb begin
         if (rst || !ok_s) begin
            rd_s = {WORD{1'b0}};
            bz_s = 1'b0;
         end else if (hit_b_s) begin
            rd_s = wdata_b;
            bz_s = 1'b0;
         end else if (hit_a_s) begin
            rd_s = wdata_a;
            bz_s = 1'b0;
         end else begin
            rd_s = mem_r[ra_s];
            bz_s = busy_r[ra_s];
         end
      end

      assign rdata[p*WORD +: WORD] = rd_s;
      assign rbusy[p]              = bz_s;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default, ZERO_R0=0 and DEPTH=24/NREAD=3 instances.
module tb_regfile_mp;

   localparam int S_D0 = 0, S_D1 = 1, S_B0 = 2, S_B1 = 3;
   localparam int S_NZD = 4, S_NZB = 5, S_DD = 6, S_DB = 9;

   typedef struct {
      string       tag;
      int          src;
      logic [31:0] exp;
   } sb_t;

   logic        clk, rst;
   logic        we_a, we_b, set_busy;
   logic [4:0]  waddr_a, waddr_b, busy_addr;
   logic [31:0] wdata_a, wdata_b;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic [1:0]  rbusy;

   logic        nz_we_a, nz_we_b, nz_set_busy;
   logic [4:0]  nz_waddr_a, nz_waddr_b, nz_busy_addr;
   logic [31:0] nz_wdata_a, nz_wdata_b;
   logic [9:0]  nz_raddr;
   logic [63:0] nz_rdata;
   logic [1:0]  nz_rbusy;

   logic        d_we_a, d_we_b, d_set_busy;
   logic [4:0]  d_waddr_a, d_waddr_b, d_busy_addr;
   logic [31:0] d_wdata_a, d_wdata_b;
   logic [14:0] d_raddr;
   logic [95:0] d_rdata;
   logic [2:0]  d_rbusy;

   logic [31:0] mem_m [32];
   logic [31:0] busy_m;
   sb_t         sb_q [$];
   int          n_checks = 0;
   int          n_errors = 0;

   regfile_mp u_dut (
      .clk(clk), .rst(rst),
      .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
      .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
      .set_busy(set_busy), .busy_addr(busy_addr),
      .raddr(raddr), .rdata(rdata), .rbusy(rbusy)
   );

   regfile_mp #(.ZERO_R0(1'b0)) u_dut_nz (
      .clk(clk), .rst(rst),
      .we_a(nz_we_a), .waddr_a(nz_waddr_a), .wdata_a(nz_wdata_a),
      .we_b(nz_we_b), .waddr_b(nz_waddr_b), .wdata_b(nz_wdata_b),
      .set_busy(nz_set_busy), .busy_addr(nz_busy_addr),
      .raddr(nz_raddr), .rdata(nz_rdata), .rbusy(nz_rbusy)
   );

   regfile_mp #(.DEPTH(24), .NREAD(3)) u_dut_24 (
      .clk(clk), .rst(rst),
      .we_a(d_we_a), .waddr_a(d_waddr_a), .wdata_a(d_wdata_a),
      .we_b(d_we_b), .waddr_b(d_waddr_b), .wdata_b(d_wdata_b),
      .set_busy(d_set_busy), .busy_addr(d_busy_addr),
      .raddr(d_raddr), .rdata(d_rdata), .rbusy(d_rbusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] get_act(input int src);
      case (src)
         S_D0:     return rdata[31:0];
         S_D1:     return rdata[63:32];
         S_B0:     return {31'd0, rbusy[0]};
         S_B1:     return {31'd0, rbusy[1]};
         S_NZD:    return nz_rdata[31:0];
         S_NZB:    return {31'd0, nz_rbusy[0]};
         S_DD:     return d_rdata[31:0];
         S_DD + 1: return d_rdata[63:32];
         S_DD + 2: return d_rdata[95:64];
         S_DB:     return {31'd0, d_rbusy[0]};
         S_DB + 1: return {31'd0, d_rbusy[1]};
         S_DB + 2: return {31'd0, d_rbusy[2]};
         default:  return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic sb_push(input string tag, input int src, input logic [31:0] exp);
      sb_t e;
      e.tag = tag;
      e.src = src;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic sb_drain();
      sb_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_eq(e.tag, get_act(e.src), e.exp);
      end
   endtask

   // Reference model of the default instance (DEPTH=32, NREAD=2, ZERO_R0=1)
   function automatic logic [31:0] m_data(input logic [4:0] a);
      if (rst || a == 5'd0) return 32'd0;
      if (we_b && waddr_b == a) return wdata_b;
      if (we_a && waddr_a == a) return wdata_a;
      return mem_m[a];
   endfunction

   function automatic logic m_busy(input logic [4:0] a);
      if (rst || a == 5'd0) return 1'b0;
      if ((we_b && waddr_b == a) || (we_a && waddr_a == a)) return 1'b0;
      return busy_m[a];
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
      busy_m = 32'd0;
   endtask

   task automatic m_update();
      if (rst) begin
         m_clear();
      end else begin
         if (we_a && waddr_a != 5'd0) begin
            mem_m[waddr_a] = wdata_a;
            busy_m[waddr_a] = 1'b0;
         end
         if (we_b && waddr_b != 5'd0) begin
            mem_m[waddr_b] = wdata_b;
            busy_m[waddr_b] = 1'b0;
         end
         if (set_busy && busy_addr != 5'd0) busy_m[busy_addr] = 1'b1;
      end
   endtask

   task automatic push_model();
      sb_push("rdata0", S_D0, m_data(raddr[4:0]));
      sb_push("rdata1", S_D1, m_data(raddr[9:5]));
      sb_push("rbusy0", S_B0, {31'd0, m_busy(raddr[4:0])});
      sb_push("rbusy1", S_B1, {31'd0, m_busy(raddr[9:5])});
   endtask

   // Inputs are set after a falling edge; check, clock, update model, return at next falling edge.
   task automatic tick();
      push_model();
      #2;
      sb_drain();
      @(posedge clk);
      m_update();
      @(negedge clk);
   endtask

   task automatic idle();
      we_a = 1'b0; we_b = 1'b0; set_busy = 1'b0;
      nz_we_a = 1'b0; nz_we_b = 1'b0; nz_set_busy = 1'b0;
      d_we_a = 1'b0; d_we_b = 1'b0; d_set_busy = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      waddr_a = 5'd0; waddr_b = 5'd0; busy_addr = 5'd0; wdata_a = 32'd0; wdata_b = 32'd0; raddr = 10'd0;
      nz_waddr_a = 5'd0; nz_waddr_b = 5'd0; nz_busy_addr = 5'd0;
      nz_wdata_a = 32'd0; nz_wdata_b = 32'd0; nz_raddr = 10'd0;
      d_waddr_a = 5'd0; d_waddr_b = 5'd0; d_busy_addr = 5'd0;
      d_wdata_a = 32'd0; d_wdata_b = 32'd0; d_raddr = 15'd0;
      m_clear();
      @(negedge clk);
      push_model();
      #1;
      sb_drain();
      rst = 1'b0;

      // Every address reads zero and not busy after reset
      for (int a = 0; a < 32; a++) begin
         raddr = {5'(31 - a), 5'(a)};
         tick();
      end

      // Port A write with same-cycle bypass, then from storage
      we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'd44; raddr = {5'd5, 5'd5};
      sb_push("bypass_a", S_D0, 32'd44);
      tick();
      idle();
      sb_push("stored_a", S_D1, 32'd44);
      tick();

      // A and B collide: B wins in bypass and storage
      we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'd23;
      we_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'd99; raddr = {5'd7, 5'd7};
      sb_push("collide_byp", S_D0, 32'd99);
      tick();
      idle();
      sb_push("collide_mem", S_D1, 32'd99);
      tick();

      // Register 0: hardwired zero on default instance, ordinary on the ZERO_R0=0 instance
      we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hDEAD; set_busy = 1'b1; busy_addr = 5'd0; raddr = 10'd0;
      nz_we_a = 1'b1; nz_waddr_a = 5'd0; nz_wdata_a = 32'hDEAD;
      nz_set_busy = 1'b1; nz_busy_addr = 5'd0; nz_raddr = 10'd0;
      sb_push("r0_byp", S_D0, 32'd0);
      sb_push("nz_r0_byp", S_NZD, 32'hDEAD);
      sb_push("nz_r0_byp_busy", S_NZB, 32'd0);
      tick();
      idle();
      sb_push("r0_read", S_D0, 32'd0);
      sb_push("r0_busy", S_B0, 32'd0);
      sb_push("nz_r0_read", S_NZD, 32'hDEAD);
      sb_push("nz_r0_busy", S_NZB, 32'd1);
      tick();

      // Scoreboard: set, retire by B write, set and write together
      set_busy = 1'b1; busy_addr = 5'd3; raddr = {5'd0, 5'd3};
      tick();
      idle();
      sb_push("busy_set", S_B0, 32'd1);
      tick();
      we_b = 1'b1; waddr_b = 5'd3; wdata_b = 32'd12;
      sb_push("busy_retire", S_B0, 32'd0);
      sb_push("retire_data", S_D0, 32'd12);
      tick();
      idle();
      sb_push("busy_cleared", S_B0, 32'd0);
      tick();
      set_busy = 1'b1; busy_addr = 5'd3; we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'd77;
      tick();
      idle();
      sb_push("busy_rearmed", S_B0, 32'd1);
      sb_push("rearm_data", S_D0, 32'd77);
      tick();

      // DEPTH=24: out-of-range write ignored and never aliases
      d_we_a = 1'b1; d_waddr_a = 5'd30; d_wdata_a = 32'd55;
      d_we_b = 1'b1; d_waddr_b = 5'd23; d_wdata_b = 32'd66;
      d_set_busy = 1'b1; d_busy_addr = 5'd30; d_raddr = {5'd14, 5'd23, 5'd30};
      sb_push("d24_inv_byp", S_DD, 32'd0);
      sb_push("d24_top_byp", S_DD + 1, 32'd66);
      sb_push("d24_alias_byp", S_DD + 2, 32'd0);
      sb_push("d24_inv_busy", S_DB, 32'd0);
      tick();
      idle();
      sb_push("d24_inv_read", S_DD, 32'd0);
      sb_push("d24_top_read", S_DD + 1, 32'd66);
      sb_push("d24_alias_read", S_DD + 2, 32'd0);
      sb_push("d24_inv_busy2", S_DB, 32'd0);
      tick();

      // Random traffic on a narrow address window to force collisions and bypasses
      for (int n = 0; n < 300; n++) begin
         we_a = 1'($urandom_range(0, 1)); waddr_a = 5'($urandom_range(0, 7)); wdata_a = $urandom;
         we_b = 1'($urandom_range(0, 1)); waddr_b = 5'($urandom_range(0, 7)); wdata_b = $urandom;
         set_busy = ($urandom_range(0, 3) == 0); busy_addr = 5'($urandom_range(0, 7));
         raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         tick();
      end
      idle();

      // Asynchronous reset between edges clears everything at once
      for (int r = 1; r <= 4; r++) begin
         we_a = 1'b1; waddr_a = 5'(r); wdata_a = 32'(r * 10);
         tick();
      end
      idle();
      raddr = {5'd2, 5'd1};
      sb_push("pre_rst_r1", S_D0, 32'd10);
      sb_push("pre_rst_r2", S_D1, 32'd20);
      push_model();
      #2;
      sb_drain();
      #1;
      rst = 1'b1;
      m_clear();
      #1;
      sb_push("async_rst_r1", S_D0, 32'd0);
      sb_push("async_rst_r2", S_D1, 32'd0);
      push_model();
      sb_drain();
      @(posedge clk);
      m_update();
      #1;
      push_model();
      sb_drain();
      @(negedge clk);
      rst = 1'b0;
      raddr = {5'd4, 5'd3};
      sb_push("post_rst_r3", S_D0, 32'd0);
      sb_push("post_rst_r4", S_D1, 32'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
